adc_peak_window_reader: RTL and testbench
=========================================

Name: adc_peak_window_reader

Overview:
- Consumer-side counterpart of the ADC max detector.
- Takes the per-clock unsigned maxima of the four ADC cores and accumulates a windowed peak per channel over a programmable number of clocks.
- Counts full-scale (saturation) samples per channel over the same window.
- Publishes a snapshot to the register/host side through a valid/ack handshake. Used for ADC gain and level monitoring.

Parameters:
- ADC_DATA_WIDTH, 8, width of each unsigned max sample.
- WIN_WIDTH, 24, width of the window-length input and window counter.
- SAT_WIDTH, 16, width of each per-channel saturation counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- adc_max_A  input  ADC_DATA_WIDTH  per-clock max, core A (unsigned).
- adc_max_B  input  ADC_DATA_WIDTH  per-clock max, core B.
- adc_max_C  input  ADC_DATA_WIDTH  per-clock max, core C.
- adc_max_D  input  ADC_DATA_WIDTH  per-clock max, core D.
- enable_i  input  1  run windows while high.
- window_len_i  input  WIN_WIDTH  samples per window; 0 is treated as 1.
- peak_ack_i  input  1  one-cycle pulse; consumes the current snapshot.
- peak_valid_o  output  1  snapshot available.
- peak_all_o  output  4*ADC_DATA_WIDTH  snapshot peaks, D in MSBs, A in LSBs.
- sat_all_o  output  4*SAT_WIDTH  snapshot saturation counts, D in MSBs.
- window_cnt_o  output  16  completed windows, wraps at 2^16.
- overrun_o  output  1  sticky: a snapshot was overwritten while unacked.

Behaviour:
- Reset: all outputs 0; state IDLE; running peaks, saturation counters and window counter 0. Reset mid-window discards everything.
- States: IDLE and ACCUM.
- IDLE → ACCUM on a clock where enable_i=1, sampled at cycle t.
  - window_len_i is captured at t; value 0 becomes 1.
  - Remaining-count register is loaded.
  - Running peaks and saturation counters are cleared.
  - Samples at cycles t+1 … t+N are accumulated.
- ACCUM, per channel, each cycle:
  - run_peak <= max(run_peak, in), unsigned compare.
  - If in == all-ones, run_sat increments, saturating at 2^SAT_WIDTH-1.
  - Remaining count decrements.
- Last sample cycle (remaining == 1):
  - Snapshot registers load the running values merged with that cycle's sample.
  - peak_valid_o = 1 from the next cycle, i.e. cycle t+N+1.
  - window_cnt_o increments.
  - Running values clear to 0.
  - If enable_i=1 on that cycle, the next window starts back-to-back with no gap: window_len_i is re-captured and its first sample is at t+N+1. Otherwise the block goes to IDLE.
- enable_i=0 during ACCUM before the last cycle:
  - The window is abandoned and the state returns to IDLE.
  - No snapshot; running values cleared; current snapshot, valid and counters untouched.
  - On the last cycle itself, the snapshot still completes.
- Handshake:
  - peak_valid_o holds until peak_ack_i; it clears the cycle after the ack.
  - peak_ack_i while peak_valid_o=0 is ignored.
  - Snapshot outputs are stable while valid=1, except on overwrite.
- Overwrite: a new snapshot loads while valid=1 and there is no ack in the same cycle. The snapshot is replaced, valid stays 1, and overrun_o sets.
  - overrun_o clears only on rst.
- Ack in the same cycle as a new snapshot load: the old snapshot is consumed, the new one loads, valid stays 1, and no overrun.
- window_len_i changes mid-window have no effect until the next window start.

Test Plan:
- Single window:
  - Stimulus: rst, then window_len_i=4, enable_i pulsed 1 cycle; A samples 0x10, 0x7F, 0x05, 0x20; B, C, D held 0x00.
  - Response: peak_valid_o=1 exactly 5 cycles after the enable cycle; peak A=0x7F, others 0x00; sat all 0; window_cnt_o=1.
- Saturation and unsigned compare:
  - Stimulus: window_len_i=3, C=0xFF, 0x80, 0xFF.
  - Response: peak C=0xFF (not treated as signed), sat C=2.
  - Stimulus: saturation counter with 70000 full-scale samples at SAT_WIDTH=16.
  - Response: sat=0xFFFF.
- Back-to-back windows:
  - Stimulus: enable_i held 1, window_len_i=2, no acks.
  - Response: snapshots at 2-cycle spacing; the second sets overrun_o=1 and window_cnt_o increments every 2 cycles.
  - Stimulus: repeat with peak_ack_i asserted on the same cycle as each load.
  - Response: overrun_o stays 0.
- Abort:
  - Stimulus: window_len_i=10, drop enable_i after 5 samples.
  - Response: no snapshot, window_cnt_o unchanged, state IDLE; next enable starts a fresh window with peaks not carried over.
- Zero length and mid-window reset:
  - Stimulus: window_len_i=0.
  - Response: behaves as 1-sample windows.
  - Stimulus: rst asserted at sample 3 of 8.
  - Response: all outputs 0 the next cycle; no snapshot after rst is released until enable_i is asserted again.

Source files
------------

// File: rtl/adc_peak_window_reader.sv
// Windowed per-channel peak and full-scale counter over the four ADC core maxima,
// published as a snapshot through a valid/ack handshake for gain/level monitoring.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   adc_max_A..D      per-clock unsigned max of each ADC core
//   enable_i          run windows while high
//   window_len_i      samples per window (0 behaves as 1), captured at window start
//   peak_ack_i        consumes the current snapshot
//   peak_valid_o      snapshot available
//   peak_all_o        snapshot peaks, D in MSBs, A in LSBs
//   sat_all_o         snapshot full-scale counts, D in MSBs
//   window_cnt_o      completed windows (wraps)
//   overrun_o         sticky: an unacked snapshot was overwritten
module adc_peak_window_reader #(
    parameter int unsigned ADC_DATA_WIDTH = 8,
    parameter int unsigned WIN_WIDTH      = 24,
    parameter int unsigned SAT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADC_DATA_WIDTH-1:0]     adc_max_A,
    input  logic [ADC_DATA_WIDTH-1:0]     adc_max_B,
    input  logic [ADC_DATA_WIDTH-1:0]     adc_max_C,
    input  logic [ADC_DATA_WIDTH-1:0]     adc_max_D,
    input  logic                          enable_i,
    input  logic [WIN_WIDTH-1:0]          window_len_i,
    input  logic                          peak_ack_i,
    output logic                          peak_valid_o,
    output logic [4*ADC_DATA_WIDTH-1:0]   peak_all_o,
    output logic [4*SAT_WIDTH-1:0]        sat_all_o,
    output logic [15:0]                   window_cnt_o,
    output logic                          overrun_o
);

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                                    state_q, state_d;
    logic [WIN_WIDTH-1:0]                      remaining_q;
    logic [NUM_CH-1:0][ADC_DATA_WIDTH-1:0]     run_peak_q;
    logic [NUM_CH-1:0][SAT_WIDTH-1:0]          run_sat_q;

    logic [NUM_CH-1:0][ADC_DATA_WIDTH-1:0]     samp_c;
    logic [NUM_CH-1:0][ADC_DATA_WIDTH-1:0]     peak_merge_c;
    logic [NUM_CH-1:0][SAT_WIDTH-1:0]          sat_merge_c;
    logic [WIN_WIDTH-1:0]                      len_eff_c;
    logic                                      start_c;
    logic                                      accum_c;
    logic                                      load_c;
    logic                                      clear_c;

    assign samp_c    = {adc_max_D, adc_max_C, adc_max_B, adc_max_A};
    assign len_eff_c = (window_len_i == '0) ? WIN_WIDTH'(1) : window_len_i;

    // Running values merged with this cycle's sample (unsigned max, saturating count).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            peak_merge_c[i] = (samp_c[i] > run_peak_q[i]) ? samp_c[i] : run_peak_q[i];
            sat_merge_c[i]  = run_sat_q[i];
            if ((samp_c[i] == '1) && (run_sat_q[i] != '1)) begin
                sat_merge_c[i] = run_sat_q[i] + SAT_WIDTH'(1);
            end
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        accum_c = 1'b0;
        load_c  = 1'b0;
        clear_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    start_c = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (remaining_q == WIN_WIDTH'(1)) begin
                    // Last sample completes even if enable drops on this cycle.
                    load_c = 1'b1;
                    if (enable_i) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable_i) begin
                    clear_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    accum_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window accumulation and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            run_peak_q   <= '0;
            run_sat_q    <= '0;
            peak_valid_o <= 1'b0;
            peak_all_o   <= '0;
            sat_all_o    <= '0;
            window_cnt_o <= '0;
            overrun_o    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (start_c) begin
                remaining_q <= len_eff_c;
            end else if (accum_c) begin
                remaining_q <= remaining_q - WIN_WIDTH'(1);
            end

            if (start_c || load_c || clear_c) begin
                run_peak_q <= '0;
                run_sat_q  <= '0;
            end else if (accum_c) begin
                run_peak_q <= peak_merge_c;
                run_sat_q  <= sat_merge_c;
            end

            if (load_c) begin
                peak_all_o   <= peak_merge_c;
                sat_all_o    <= sat_merge_c;
                peak_valid_o <= 1'b1;
                window_cnt_o <= window_cnt_o + 16'd1;
                // An ack arriving with the load consumes the old snapshot.
                if (peak_valid_o && !peak_ack_i) begin
                    overrun_o <= 1'b1;
                end
            end else if (peak_ack_i && peak_valid_o) begin
                peak_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_peak_window_reader.sv
// Directed-vector bench for adc_peak_window_reader with a scoreboard monitor that
// checks every snapshot load against queued hand-computed expectations.
module tb_adc_peak_window_reader;

    typedef struct {
        logic [31:0] peak;
        logic [63:0] sat;
        logic [15:0] cnt;
        logic        ovr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] peak;
        logic [15:0] sat;
    } exp2_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a, b, c, d;
    logic        en, ack, en2;
    logic [23:0] len;
    logic        valid, ovr;
    logic [31:0] peak;
    logic [63:0] sat;
    logic [15:0] cnt;
    logic        valid2, ovr2;
    logic [31:0] peak2;
    logic [15:0] sat2;
    logic [15:0] cnt2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t  q[$];
    exp2_t q2[$];

    adc_peak_window_reader dut (
        .clk(clk), .rst(rst),
        .adc_max_A(a), .adc_max_B(b), .adc_max_C(c), .adc_max_D(d),
        .enable_i(en), .window_len_i(len), .peak_ack_i(ack),
        .peak_valid_o(valid), .peak_all_o(peak), .sat_all_o(sat),
        .window_cnt_o(cnt), .overrun_o(ovr)
    );

    // Narrow saturation counters make the clamp reachable in a few cycles.
    adc_peak_window_reader #(.ADC_DATA_WIDTH(8), .WIN_WIDTH(24), .SAT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .adc_max_A(a), .adc_max_B(b), .adc_max_C(c), .adc_max_D(d),
        .enable_i(en2), .window_len_i(24'd20), .peak_ack_i(1'b0),
        .peak_valid_o(valid2), .peak_all_o(peak2), .sat_all_o(sat2),
        .window_cnt_o(cnt2), .overrun_o(ovr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs; they are sampled at the following posedge.
    task automatic drive(input logic [7:0] va, vb, vc, vd, input logic ven, vack);
        a = va; b = vb; c = vc; d = vd; en = ven; ack = vack;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] p, input logic [63:0] s, input logic [15:0] n,
                        input logic o, input int t);
        exp_t e;
        e.peak = p; e.sat = s; e.cnt = n; e.ovr = o; e.cyc = t;
        q.push_back(e);
    endtask

    // Monitor: a change of the window count marks a snapshot load.
    initial begin : monitor
        logic [15:0] prev = 16'd0;
        logic [15:0] prev2 = 16'd0;
        exp_t  e;
        exp2_t e2;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev  = cnt;
                prev2 = cnt2;
            end else begin
                if (cnt !== prev) begin
                    prev = cnt;
                    if (q.size() == 0) begin
                        chk("unexpected_snapshot", 64'(cnt), 64'(16'hffff));
                    end else begin
                        e = q.pop_front();
                        chk("snap_peak", 64'(peak), 64'(e.peak));
                        chk("snap_sat", sat, e.sat);
                        chk("snap_cnt", 64'(cnt), 64'(e.cnt));
                        chk("snap_valid", 64'(valid), 64'd1);
                        chk("snap_overrun", 64'(ovr), 64'(e.ovr));
                        if (e.cyc >= 0) chk("snap_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (cnt2 !== prev2) begin
                    prev2 = cnt2;
                    if (q2.size() == 0) begin
                        chk("unexpected_snapshot2", 64'(cnt2), 64'(16'hffff));
                    end else begin
                        e2 = q2.pop_front();
                        chk("snap2_peak", 64'(peak2), 64'(e2.peak));
                        chk("snap2_sat", 64'(sat2), 64'(e2.sat));
                    end
                end
            end
        end
    end

    initial begin : stim
        int e0;
        exp2_t x2;
        rst = 1'b1; en2 = 1'b0; len = 24'd0;
        a = 0; b = 0; c = 0; d = 0; en = 0; ack = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_peak", 64'(peak), 64'd0);
        chk("rst_sat", sat, 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_overrun", 64'(ovr), 64'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Single window, len 4; the enable-cycle sample 0xEE must not count.
        len = 24'd4;
        e0 = cyc + 1;
        push(32'h0000007F, 64'd0, 16'd1, 1'b0, e0 + 4);
        drive(8'hEE, 0, 0, 0, 1, 0);
        drive(8'h10, 0, 0, 0, 1, 0);
        drive(8'h7F, 0, 0, 0, 1, 0);
        drive(8'h05, 0, 0, 0, 1, 0);
        drive(8'h20, 0, 0, 0, 0, 0);
        chk("valid_held", 64'(valid), 64'd1);
        drive(0, 0, 0, 0, 0, 1);
        chk("valid_after_ack", 64'(valid), 64'd0);

        // Full-scale counting and unsigned compare on channel C.
        len = 24'd3;
        e0 = cyc + 1;
        push(32'h00FF0000, 64'h0000_0002_0000_0000, 16'd2, 1'b0, e0 + 3);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 8'hFF, 0, 1, 0);
        drive(0, 0, 8'h80, 0, 1, 0);
        drive(0, 0, 8'hFF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);

        // Back-to-back len 2 windows, no acks: second and third overrun.
        len = 24'd2;
        e0 = cyc + 1;
        push(32'h00002200, 64'd0, 16'd3, 1'b0, e0 + 2);
        push(32'hFF000000, 64'h0001_0000_0000_0000, 16'd4, 1'b1, e0 + 4);
        push(32'h00000003, 64'd0, 16'd5, 1'b1, e0 + 6);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 8'h11, 0, 0, 1, 0);
        drive(0, 8'h22, 0, 0, 1, 0);
        drive(0, 0, 0, 8'hFF, 1, 0);
        drive(0, 0, 0, 8'h01, 1, 0);
        drive(8'h03, 0, 0, 0, 1, 0);
        drive(8'h02, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk("overrun_sticky", 64'(ovr), 64'd1);
        chk("valid_after_ack2", 64'(valid), 64'd0);

        // Back-to-back with ack coinciding with each load: no overrun.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        e0 = cyc + 1;
        push(32'h00000041, 64'd0, 16'd1, 1'b0, e0 + 2);
        push(32'h00000201, 64'd0, 16'd2, 1'b0, e0 + 4);
        drive(0, 0, 0, 0, 1, 0);
        drive(8'h40, 0, 0, 0, 1, 0);
        drive(8'h41, 0, 0, 0, 1, 1);
        drive(8'h01, 0, 0, 0, 1, 0);
        drive(0, 8'h02, 0, 0, 0, 1);
        chk("ack_load_overrun", 64'(ovr), 64'd0);
        chk("ack_load_valid", 64'(valid), 64'd1);
        drive(0, 0, 0, 0, 0, 1);

        // Abort after 5 of 10 samples; then a fresh window starts clean.
        len = 24'd10;
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(8'h90, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("abort_cnt", 64'(cnt), 64'd2);
        chk("abort_valid", 64'(valid), 64'd0);
        len = 24'd2;
        e0 = cyc + 1;
        push(32'h00000006, 64'd0, 16'd3, 1'b0, e0 + 2);
        drive(0, 0, 0, 0, 1, 0);
        drive(8'h05, 0, 0, 0, 1, 0);
        drive(8'h06, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);

        // Zero length behaves as one-sample windows.
        len = 24'd0;
        e0 = cyc + 1;
        push(32'h00000007, 64'd0, 16'd4, 1'b0, e0 + 1);
        push(32'h00000008, 64'd0, 16'd5, 1'b0, e0 + 2);
        drive(0, 0, 0, 0, 1, 0);
        drive(8'h07, 0, 0, 0, 1, 0);
        drive(8'h08, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        // Reset at sample 3 of 8, then idle: no snapshot may appear.
        len = 24'd8;
        drive(0, 0, 0, 0, 1, 0);
        drive(8'h33, 0, 0, 0, 1, 0);
        drive(8'h33, 0, 0, 0, 1, 0);
        rst = 1'b1;
        drive(8'h33, 0, 0, 0, 1, 0);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_peak", 64'(peak), 64'd0);
        chk("midrst_sat", sat, 64'd0);
        chk("midrst_cnt", 64'(cnt), 64'd0);
        chk("midrst_overrun", 64'(ovr), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) drive(8'hFF, 0, 0, 0, 0, 0);
        chk("midrst_idle_cnt", 64'(cnt), 64'd0);
        chk("midrst_idle_valid", 64'(valid), 64'd0);

        // Saturation clamp on the narrow-counter instance: 20 full-scale samples.
        x2.peak = 32'h00FF0000;
        x2.sat  = 16'h0F00;
        q2.push_back(x2);
        en2 = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) drive(0, 0, 8'hFF, 0, 0, 0);
        en2 = 1'b0;
        drive(0, 0, 8'hFF, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("sat2_cnt", 64'(cnt2), 64'd1);

        chk("pending_snapshots", 64'(q.size()), 64'd0);
        chk("pending_snapshots2", 64'(q2.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
